rat_ckpt: RTL and testbench
===========================

RAT_CKPT -- requirements
Module: rat_ckpt

Interface
REQ-001 Parameter NUM_ARCH, default 32, number of architectural registers; index 0 is hard-wired zero.
REQ-002 Parameter NUM_PHYS, default 256, number of physical tags; tag NUM_PHYS-1 is PHYS_NONE.
REQ-003 Parameter NUM_CKPT, default 8, checkpoint slots (power of two); derived AW=clog2(NUM_ARCH), PW=clog2(NUM_PHYS), CW=clog2(NUM_CKPT).
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ren_valid / ren_ready  in / out  1 / 1  rename request handshake; transfer when both high.
REQ-007 src1_arch, src2_arch, rd_arch  in  AW each  source and destination architectural indices.
REQ-008 src1_use, src2_use, rd_use  in  1 each  operand-present flags.
REQ-009 free_tag  in  PW  free physical tag offered by the free list, consumed when rd is renamed.
REQ-010 ckpt_req  in  1  request a checkpoint with this rename (branch/jump).
REQ-011 out_valid  out  1; src1_phys, src2_phys, rd_phys, old_phys  out  PW each; ckpt_id  out  CW.
REQ-012 commit_valid  in  1  release the oldest checkpoint (branch resolved correct).
REQ-013 flush_valid  in  1; flush_id  in  CW  mispredict: restore the map from checkpoint flush_id.
REQ-014 ckpt_full, ckpt_empty  out  1 each  checkpoint buffer status.

Function
REQ-015 The map table SHALL hold NUM_ARCH entries of PW bits; entry 0 SHALL always read 0 and never be written.
REQ-016 Rename results SHALL be registered: outputs appear with out_valid=1 exactly one cycle after the transfer, else out_valid=0 with data held.
REQ-017 srcN_phys SHALL be map[srcN_arch] when srcN_use=1, PHYS_NONE otherwise.
REQ-018 Sources SHALL read the map before the same instruction's rd update (rd==src returns the old tag).
REQ-019 When rd_use=1 and rd_arch!=0: map[rd_arch] <= free_tag, rd_phys=free_tag, old_phys=previous map[rd_arch].
REQ-020 When rd_use=0 or rd_arch==0: map unchanged, rd_phys=PHYS_NONE, old_phys=free_tag (tag returned to the free list).
REQ-021 Checkpoints SHALL form a circular buffer with head, tail (CW bits, wrapping) and count (CW+1 bits).
REQ-022 On a transfer with ckpt_req=1, slot[tail] SHALL capture the map after this instruction's rd update; ckpt_id=tail; tail increments.
REQ-023 ren_ready SHALL be 0 when flush_valid=1, or when ckpt_req=1 and count==NUM_CKPT; otherwise 1. It is computed from current state, with no same-cycle bypass of commit.
REQ-024 commit_valid=1 with count>0 SHALL advance head; commit with count==0 SHALL be ignored.
REQ-025 flush_valid=1 SHALL copy slot[flush_id] into the map and set tail=flush_id+1, freeing all younger checkpoints; flush_id must lie in [head,tail).
REQ-026 Simultaneous commit and flush: commit applies first, then flush; flush_id==old head with commit SHALL leave the buffer empty, and the map is still restored.
REQ-027 A flush cycle SHALL suppress the rename transfer (ren_ready=0) and force out_valid=0 in the following cycle.
REQ-028 count SHALL equal the tail-minus-head occupancy; ckpt_full=(count==NUM_CKPT) and ckpt_empty=(count==0), both combinational from state.

Reset
REQ-029 On reset: map[i]=i for all i, head=tail=count=0, out_valid=0, and all PW outputs=0.
REQ-030 Reset SHALL override any concurrent rename, commit or flush in the same cycle.
REQ-031 Checkpoint slot contents need not be reset; they are never read unless allocated.

Structure
REQ-032 A shared package rat_pkg SHALL hold the default parameters, PHYS_NONE, and the tag/ckpt-id typedefs.
REQ-033 One sub-module, rat_ckpt_slot (a NUM_ARCH x PW snapshot register with write-enable), SHALL be instantiated NUM_CKPT times.

Verification
REQ-034 Reset, then rename src1=5, src2=6, rd=5, free_tag=40 -> next cycle src1_phys=5, src2_phys=6, rd_phys=40, old_phys=5; a later read of r5 returns 40.
REQ-035 Rename rd=0, rd_use=1, free_tag=77 -> rd_phys=PHYS_NONE, old_phys=77, map[0] stays 0.
REQ-036 Issue 8 ckpt_req renames -> ckpt_ids 0..7, ckpt_full=1, ninth ckpt_req sees ren_ready=0; a commit that cycle leaves ren_ready=0, and the request is accepted the next cycle as ckpt_id 0.
REQ-037 Checkpoint at id 2 (r3 mapped to 3), then rename r3->90 and take two more checkpoints, then flush_id=2 -> r3 reads 3, count=3 (ids 0..2), next checkpoint id=3.
REQ-038 Commit and flush with flush_id=head in the same cycle -> ckpt_empty=1 and the map is restored from that slot.
REQ-039 Assert reset mid-stream with 5 checkpoints live -> next cycle identity map, ckpt_empty=1, out_valid=0.

Source files
------------

// File: rtl/rat_pkg.sv
// Shared defaults and tag / checkpoint-id types for the rename map with checkpoints.
package rat_pkg;
    localparam int RAT_NUM_ARCH = 32;
    localparam int RAT_NUM_PHYS = 256;
    localparam int RAT_NUM_CKPT = 8;
    localparam int RAT_PW       = $clog2(RAT_NUM_PHYS);
    localparam int RAT_CW       = $clog2(RAT_NUM_CKPT);

    typedef logic [RAT_PW-1:0] phys_tag_t;
    typedef logic [RAT_CW-1:0] ckpt_id_t;

    localparam phys_tag_t PHYS_NONE = phys_tag_t'(RAT_NUM_PHYS - 1);
endpackage

// File: rtl/rat_ckpt_slot.sv
// One checkpoint slot: a full snapshot of the rename map, loaded when we is high.
module rat_ckpt_slot
    import rat_pkg::*;
#(
    parameter int NUM_ARCH = RAT_NUM_ARCH,
    parameter int PW       = RAT_PW
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [NUM_ARCH-1:0][PW-1:0]  map_in,
    output logic [NUM_ARCH-1:0][PW-1:0]  map_out
);
    logic [NUM_ARCH-1:0][PW-1:0] snap_q, snap_d;

    always_comb begin
        snap_d = we ? map_in : snap_q;
    end

    always_ff @(posedge clk) begin
        snap_q <= snap_d;
    end

    assign map_out = snap_q;
endmodule

// File: rtl/rat_ckpt.sv
// Register alias table with a circular buffer of map checkpoints for branch recovery.
module rat_ckpt
    import rat_pkg::*;
#(
    parameter int NUM_ARCH = RAT_NUM_ARCH,
    parameter int NUM_PHYS = RAT_NUM_PHYS,
    parameter int NUM_CKPT = RAT_NUM_CKPT,
    localparam int AW = $clog2(NUM_ARCH),
    localparam int PW = $clog2(NUM_PHYS),
    localparam int CW = $clog2(NUM_CKPT)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ren_valid,
    output logic          ren_ready,
    input  logic [AW-1:0] src1_arch,
    input  logic [AW-1:0] src2_arch,
    input  logic [AW-1:0] rd_arch,
    input  logic          src1_use,
    input  logic          src2_use,
    input  logic          rd_use,
    input  logic [PW-1:0] free_tag,
    input  logic          ckpt_req,
    output logic          out_valid,
    output logic [PW-1:0] src1_phys,
    output logic [PW-1:0] src2_phys,
    output logic [PW-1:0] rd_phys,
    output logic [PW-1:0] old_phys,
    output logic [CW-1:0] ckpt_id,
    input  logic          commit_valid,
    input  logic          flush_valid,
    input  logic [CW-1:0] flush_id,
    output logic          ckpt_full,
    output logic          ckpt_empty
);
    localparam logic [PW-1:0] TAG_NONE = PW'(NUM_PHYS - 1);
    localparam logic [CW:0]   FULL_CNT = (CW+1)'(NUM_CKPT);

    logic [NUM_ARCH-1:0][PW-1:0] map_q, map_d, map_ren;
    logic [NUM_ARCH-1:0][PW-1:0] slot_map [NUM_CKPT];
    logic [NUM_CKPT-1:0]         slot_we;

    logic [CW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW:0]   count_q, count_d;
    logic          out_valid_q, out_valid_d;
    logic [PW-1:0] src1_phys_q, src1_phys_d, src2_phys_q, src2_phys_d;
    logic [PW-1:0] rd_phys_q, rd_phys_d, old_phys_q, old_phys_d;
    logic [CW-1:0] ckpt_id_q, ckpt_id_d;

    logic transfer, alloc, commit_go, rd_write;

    assign ckpt_full  = (count_q == FULL_CNT);
    assign ckpt_empty = (count_q == '0);
    assign ren_ready  = !flush_valid && !(ckpt_req && ckpt_full);

    always_comb begin
        transfer  = ren_valid && ren_ready;
        alloc     = transfer && ckpt_req;
        commit_go = commit_valid && !ckpt_empty;
        rd_write  = rd_use && (rd_arch != '0);

        // Sources read map_q, so rd==src sees the pre-rename tag.
        map_ren = map_q;
        if (transfer && rd_write) begin
            map_ren[rd_arch] = free_tag;
        end
        map_d    = flush_valid ? slot_map[flush_id] : map_ren;
        map_d[0] = '0;

        slot_we = '0;
        if (alloc) begin
            slot_we[tail_q] = 1'b1;
        end

        out_valid_d = transfer;
        src1_phys_d = src1_phys_q;
        src2_phys_d = src2_phys_q;
        rd_phys_d   = rd_phys_q;
        old_phys_d  = old_phys_q;
        ckpt_id_d   = ckpt_id_q;
        if (transfer) begin
            src1_phys_d = src1_use ? map_q[src1_arch] : TAG_NONE;
            src2_phys_d = src2_use ? map_q[src2_arch] : TAG_NONE;
            rd_phys_d   = rd_write ? free_tag : TAG_NONE;
            old_phys_d  = rd_write ? map_q[rd_arch] : free_tag;
            ckpt_id_d   = tail_q;
        end

        // Commit retires first; the flush then keeps [old head .. flush_id] minus that commit.
        head_d = head_q + CW'(commit_go);
        if (flush_valid) begin
            tail_d  = flush_id + CW'(1);
            count_d = {1'b0, CW'(flush_id - head_q)} + (CW+1)'(1) - (CW+1)'(commit_go);
        end else begin
            tail_d  = tail_q + CW'(alloc);
            count_d = count_q + (CW+1)'(alloc) - (CW+1)'(commit_go);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_ARCH; i++) begin
                map_q[i] <= PW'(i);
            end
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            src1_phys_q <= '0;
            src2_phys_q <= '0;
            rd_phys_q   <= '0;
            old_phys_q  <= '0;
            ckpt_id_q   <= '0;
        end else begin
            map_q       <= map_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            src1_phys_q <= src1_phys_d;
            src2_phys_q <= src2_phys_d;
            rd_phys_q   <= rd_phys_d;
            old_phys_q  <= old_phys_d;
            ckpt_id_q   <= ckpt_id_d;
        end
    end

    for (genvar g = 0; g < NUM_CKPT; g++) begin : g_slot
        rat_ckpt_slot #(
            .NUM_ARCH(NUM_ARCH),
            .PW(PW)
        ) u_slot (
            .clk(clk),
            .we(slot_we[g]),
            .map_in(map_ren),
            .map_out(slot_map[g])
        );
    end

    assign out_valid = out_valid_q;
    assign src1_phys = src1_phys_q;
    assign src2_phys = src2_phys_q;
    assign rd_phys   = rd_phys_q;
    assign old_phys  = old_phys_q;
    assign ckpt_id   = ckpt_id_q;
endmodule

// File: tb/tb_rat_ckpt.sv
// Bench for rat_ckpt: directed scenarios plus random traffic against a queue-based map model.
module tb_rat_ckpt;
    localparam int NA   = 32;
    localparam int NC   = 8;
    localparam int NONE = 255;

    logic       clk = 1'b0;
    logic       reset, ren_valid, ren_ready;
    logic [4:0] src1_arch, src2_arch, rd_arch;
    logic       src1_use, src2_use, rd_use, ckpt_req;
    logic [7:0] free_tag;
    logic       out_valid;
    logic [7:0] src1_phys, src2_phys, rd_phys, old_phys;
    logic [2:0] ckpt_id;
    logic       commit_valid, flush_valid;
    logic [2:0] flush_id;
    logic       ckpt_full, ckpt_empty;

    rat_ckpt dut (
        .clk(clk), .reset(reset), .ren_valid(ren_valid), .ren_ready(ren_ready),
        .src1_arch(src1_arch), .src2_arch(src2_arch), .rd_arch(rd_arch),
        .src1_use(src1_use), .src2_use(src2_use), .rd_use(rd_use),
        .free_tag(free_tag), .ckpt_req(ckpt_req),
        .out_valid(out_valid), .src1_phys(src1_phys), .src2_phys(src2_phys),
        .rd_phys(rd_phys), .old_phys(old_phys), .ckpt_id(ckpt_id),
        .commit_valid(commit_valid), .flush_valid(flush_valid), .flush_id(flush_id),
        .ckpt_full(ckpt_full), .ckpt_empty(ckpt_empty)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Reference model: map as an int array, live checkpoints as an ordered id queue.
    int mmap [NA];
    int snap [NC][NA];
    int q [$];
    int tail;
    bit init = 0;
    int e_ov, e_s1, e_s2, e_rd, e_old, e_id;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NA; i++) mmap[i] = i;
            q.delete();
            tail = 0;
            e_ov = 0; e_s1 = 0; e_s2 = 0; e_rd = 0; e_old = 0; e_id = 0;
            init = 1;
        end else if (init) begin
            bit cm, rdy, xfer, found;
            cm   = commit_valid && (q.size() > 0);
            rdy  = !flush_valid && !(ckpt_req && q.size() == NC);
            xfer = ren_valid && rdy;
            e_ov = xfer;
            if (xfer) begin
                e_s1 = src1_use ? mmap[src1_arch] : NONE;
                e_s2 = src2_use ? mmap[src2_arch] : NONE;
                if (rd_use && rd_arch != 0) begin
                    e_old = mmap[rd_arch];
                    mmap[rd_arch] = free_tag;
                    e_rd = free_tag;
                end else begin
                    e_rd = NONE;
                    e_old = free_tag;
                end
                e_id = tail;
                if (ckpt_req) begin
                    snap[tail] = mmap;
                    q.push_back(tail);
                    tail = (tail + 1) % NC;
                end
            end
            if (cm) void'(q.pop_front());
            if (flush_valid) begin
                found = 0;
                foreach (q[k]) if (q[k] == flush_id) found = 1;
                if (found) while (q[$] != flush_id) void'(q.pop_back());
                else q.delete();
                mmap = snap[flush_id];
                tail = (flush_id + 1) % NC;
            end
        end
        #2;
        if (init) begin
            chk("out_valid", out_valid, e_ov);
            chk("src1_phys", src1_phys, e_s1);
            chk("src2_phys", src2_phys, e_s2);
            chk("rd_phys", rd_phys, e_rd);
            chk("old_phys", old_phys, e_old);
            chk("ckpt_id", ckpt_id, e_id);
            chk("ckpt_full", ckpt_full, q.size() == NC);
            chk("ckpt_empty", ckpt_empty, q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (init && !reset)
            chk("ren_ready", ren_ready, !flush_valid && !(ckpt_req && q.size() == NC));
    end

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic clr();
        ren_valid = 0; src1_arch = 0; src2_arch = 0; rd_arch = 0;
        src1_use = 0; src2_use = 0; rd_use = 0; free_tag = 0; ckpt_req = 0;
        commit_valid = 0; flush_valid = 0; flush_id = 0;
    endtask

    task automatic do_reset();
        clr();
        reset = 1;
        tick();
        reset = 0;
    endtask

    initial begin
        reset = 1;
        clr();
        tick();
        tick();
        reset = 0;
        chk("lit_reset_valid", out_valid, 0);
        chk("lit_reset_rd", rd_phys, 0);
        chk("lit_reset_empty", ckpt_empty, 1);

        // Basic rename with rd == src1
        ren_valid = 1; src1_use = 1; src1_arch = 5; src2_use = 1; src2_arch = 6;
        rd_use = 1; rd_arch = 5; free_tag = 40;
        tick();
        clr();
        chk("lit_s1", src1_phys, 5);
        chk("lit_s2", src2_phys, 6);
        chk("lit_rd", rd_phys, 40);
        chk("lit_old", old_phys, 5);
        ren_valid = 1; src1_use = 1; src1_arch = 5; free_tag = 41;
        tick();
        clr();
        chk("lit_r5_read", src1_phys, 40);
        chk("lit_nord_rd", rd_phys, NONE);
        chk("lit_nord_old", old_phys, 41);

        // rd = r0 is never renamed
        ren_valid = 1; rd_use = 1; rd_arch = 0; free_tag = 77; src1_use = 1; src1_arch = 0;
        tick();
        clr();
        chk("lit_r0_rd", rd_phys, NONE);
        chk("lit_r0_old", old_phys, 77);
        chk("lit_r0_src", src1_phys, 0);

        // Fill all slots, then a blocked request with a concurrent commit
        do_reset();
        for (int i = 0; i < NC; i++) begin
            ren_valid = 1; ckpt_req = 1;
            tick();
            chk("lit_fill_id", ckpt_id, i);
        end
        chk("lit_full", ckpt_full, 1);
        commit_valid = 1;
        #1 chk("lit_full_ready", ren_ready, 0);
        tick();
        commit_valid = 0;
        chk("lit_blocked_valid", out_valid, 0);
        #1 chk("lit_ready_after_commit", ren_ready, 1);
        tick();
        clr();
        chk("lit_wrap_valid", out_valid, 1);
        chk("lit_wrap_id", ckpt_id, 0);

        // Flush back to checkpoint 2
        do_reset();
        ren_valid = 1; ckpt_req = 1;
        tick(); tick(); tick();
        chk("lit_ckpt2", ckpt_id, 2);
        ckpt_req = 0; rd_use = 1; rd_arch = 3; free_tag = 90;
        tick();
        rd_use = 0; ckpt_req = 1;
        tick(); tick();
        flush_valid = 1; flush_id = 2;
        #1 chk("lit_flush_ready", ren_ready, 0);
        tick();
        clr();
        chk("lit_flush_valid", out_valid, 0);
        ren_valid = 1; ckpt_req = 1; src1_use = 1; src1_arch = 3;
        tick();
        clr();
        chk("lit_flush_r3", src1_phys, 3);
        chk("lit_flush_next_id", ckpt_id, 3);

        // Commit and flush of the head together
        do_reset();
        ren_valid = 1; ckpt_req = 1; rd_use = 1; rd_arch = 7; free_tag = 100;
        tick();
        free_tag = 101;
        tick();
        clr();
        commit_valid = 1; flush_valid = 1; flush_id = 0;
        tick();
        clr();
        chk("lit_cf_empty", ckpt_empty, 1);
        ren_valid = 1; src1_use = 1; src1_arch = 7;
        tick();
        clr();
        chk("lit_cf_r7", src1_phys, 100);

        // Reset with live checkpoints
        do_reset();
        for (int i = 0; i < 5; i++) begin
            ren_valid = 1; ckpt_req = 1; rd_use = 1; rd_arch = 5'(i + 1); free_tag = 8'(200 + i);
            tick();
        end
        reset = 1; commit_valid = 1;
        tick();
        clr();
        reset = 0;
        chk("lit_rst_valid", out_valid, 0);
        chk("lit_rst_empty", ckpt_empty, 1);
        chk("lit_rst_rd", rd_phys, 0);
        ren_valid = 1; src1_use = 1; src1_arch = 3; src2_use = 1; src2_arch = 1;
        tick();
        clr();
        chk("lit_rst_r3", src1_phys, 3);
        chk("lit_rst_r1", src2_phys, 1);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            clr();
            reset        = ($urandom_range(0, 99) == 0);
            ren_valid    = ($urandom_range(0, 3) != 0);
            src1_arch    = 5'($urandom_range(0, 31));
            src2_arch    = 5'($urandom_range(0, 31));
            rd_arch      = 5'($urandom_range(0, 31));
            src1_use     = $urandom_range(0, 1);
            src2_use     = $urandom_range(0, 1);
            rd_use       = ($urandom_range(0, 3) != 0);
            free_tag     = 8'($urandom_range(0, 254));
            ckpt_req     = ($urandom_range(0, 2) == 0);
            commit_valid = ($urandom_range(0, 3) == 0);
            if (q.size() > 0 && $urandom_range(0, 9) == 0) begin
                flush_valid = 1;
                flush_id    = 3'(q[$urandom_range(0, q.size() - 1)]);
            end
            tick();
        end
        clr();
        reset = 0;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
